// File: rtl/m_store_buffer.sv
// rtl/m_store_buffer.sv - four-entry FIFO store buffer with DM drain port and byte-lane load forwarding
module m_store_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wd,
    input  logic [3:0]  st_be,
    input  logic [31:0] st_pc,
    output logic        st_ready,
    input  logic        drain_en,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_pc,
    input  logic [31:0] ld_addr,
    input  logic [31:0] dm_rd,
    output logic [31:0] ld_data,
    output logic [2:0]  count,
    output logic        empty,
    output logic        full
);

    logic [29:0] e_addr [4];
    logic [31:0] e_wd   [4];
    logic [3:0]  e_be   [4];
    logic [31:0] e_pc   [4];

    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  cnt;
    logic        push;
    logic        pop;
    logic [1:0]  fwd_idx;

    // Byte offsets are meaningless for a word-granular buffer.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign count    = cnt;
    assign empty    = (cnt == 3'd0);
    assign full     = (cnt == 3'd4);
    assign st_ready = !full;

    assign push  = st_valid && !full;
    assign dm_we = !empty && drain_en;
    assign pop   = dm_we;

    assign dm_addr = {e_addr[rd_ptr], 2'b00};
    assign dm_wd   = e_wd[rd_ptr];
    assign dm_be   = e_be[rd_ptr];
    assign dm_pc   = e_pc[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            cnt    <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            e_addr[wr_ptr] <= st_addr[31:2];
            e_wd[wr_ptr]   <= st_wd;
            e_be[wr_ptr]   <= st_be;
            e_pc[wr_ptr]   <= st_pc;
        end
    end

    // Walk oldest to youngest so the youngest matching byte wins each lane.
    always_comb begin
        ld_data = dm_rd;
        fwd_idx = rd_ptr;
        for (int k = 0; k < 4; k++) begin
            fwd_idx = rd_ptr + 2'(k);
            if ((3'(k) < cnt) && (e_addr[fwd_idx] == ld_addr[31:2])) begin
                for (int i = 0; i < 4; i++) begin
                    if (e_be[fwd_idx][i]) ld_data[8*i +: 8] = e_wd[fwd_idx][8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_m_store_buffer.sv
// tb/tb_m_store_buffer.sv - randomized and directed self-checking bench for m_store_buffer
module tb_m_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_wd;
    logic [3:0]  st_be;
    logic [31:0] st_pc;
    logic        st_ready;
    logic        drain_en;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [3:0]  dm_be;
    logic [31:0] dm_pc;
    logic [31:0] ld_addr;
    logic [31:0] dm_rd;
    logic [31:0] ld_data;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [29:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] pc;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    m_store_buffer dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_wd(st_wd), .st_be(st_be), .st_pc(st_pc),
        .st_ready(st_ready), .drain_en(drain_en),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_be(dm_be), .dm_pc(dm_pc),
        .ld_addr(ld_addr), .dm_rd(dm_rd), .ld_data(ld_data),
        .count(count), .empty(empty), .full(full)
    );

    // Memory image a load would see if every buffered store had already landed.
    function automatic logic [31:0] model_ld(input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] r;
        r = rd;
        foreach (q[j]) begin
            if (q[j].a == a[31:2]) begin
                for (int i = 0; i < 4; i++) if (q[j].be[i]) r[8*i +: 8] = q[j].wd[8*i +: 8];
            end
        end
        return r;
    endfunction

    task automatic model_step();
        ent_t e;
        bit do_pop;
        bit do_push;
        if (reset) begin
            q.delete();
        end else begin
            do_pop  = (q.size() != 0) && drain_en;
            do_push = st_valid && (q.size() != 4);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.a = st_addr[31:2]; e.wd = st_wd; e.be = st_be; e.pc = st_pc;
                q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] pc, input logic de);
        st_valid = v; st_addr = a; st_wd = wd; st_be = be; st_pc = pc; drain_en = de;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        tick();
        reset = 1'b0;
        ld_addr = 32'h40; dm_rd = 32'h5A5AC3C3;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || st_ready !== 1'b1 || dm_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got cnt=%0d e=%b f=%b rdy=%b we=%b exp cnt=0 e=1 f=0 rdy=1 we=0",
                     count, empty, full, st_ready, dm_we);
        end
        checks++;
        if (ld_data !== 32'h5A5AC3C3) begin
            errors++; $display("FAIL reset_ld got %h exp %h", ld_data, 32'h5A5AC3C3);
        end
    endtask

    task automatic test_basic_drain();
        drive(1'b1, 32'h10, 32'hAABBCCDD, 4'hF, 32'h1000, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        checks++;
        if (count !== 3'd1 || dm_we !== 1'b0) begin
            errors++; $display("FAIL basic_count got cnt=%0d we=%b exp cnt=1 we=0", count, dm_we);
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
        checks++;
        if (dm_we !== 1'b1 || dm_addr !== 32'h10 || dm_wd !== 32'hAABBCCDD || dm_be !== 4'hF || dm_pc !== 32'h1000) begin
            errors++;
            $display("FAIL basic_drain got we=%b a=%h wd=%h be=%h pc=%h exp we=1 a=00000010 wd=aabbccdd be=f pc=00001000",
                     dm_we, dm_addr, dm_wd, dm_be, dm_pc);
        end
        tick();
        checks++;
        if (empty !== 1'b1 || dm_we !== 1'b0) begin
            errors++; $display("FAIL basic_empty got e=%b we=%b exp e=1 we=0", empty, dm_we);
        end
        // Store into an empty buffer is not drainable in its own cycle.
        drive(1'b1, 32'h14, 32'h01020304, 4'hF, 32'h1004, 1'b1);
        checks++;
        if (dm_we !== 1'b0) begin
            errors++; $display("FAIL no_bypass got we=%b exp 0", dm_we);
        end
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
        checks++;
        if (dm_we !== 1'b1 || dm_wd !== 32'h01020304) begin
            errors++; $display("FAIL latency1 got we=%b wd=%h exp we=1 wd=01020304", dm_we, dm_wd);
        end
        tick();
    endtask

    task automatic test_full_drop();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h100 + 32'(4*i), 32'hC0DE0000 | 32'(i), 4'hF, 32'h2000 + 32'(i), 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        checks++;
        if (full !== 1'b1 || st_ready !== 1'b0 || count !== 3'd4) begin
            errors++; $display("FAIL full_flags got f=%b rdy=%b cnt=%0d exp f=1 rdy=0 cnt=4", full, st_ready, count);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
            checks++;
            if (dm_we !== 1'b1 || dm_wd !== (32'hC0DE0000 | 32'(i)) || dm_pc !== 32'h2000 + 32'(i)) begin
                errors++;
                $display("FAIL full_order%0d got we=%b wd=%h pc=%h exp we=1 wd=%h pc=%h", i, dm_we, dm_wd, dm_pc,
                         32'hC0DE0000 | 32'(i), 32'h2000 + 32'(i));
            end
            tick();
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++; $display("FAIL full_drop5 got e=%b exp 1", empty);
        end
    endtask

    task automatic test_forward();
        drive(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h3000, 1'b0);
        tick();
        drive(1'b1, 32'h20, 32'h000000EE, 4'h1, 32'h3004, 1'b0);
        ld_addr = 32'h22; dm_rd = 32'h0; #1;
        checks++;
        if (ld_data !== 32'h11223344) begin
            errors++; $display("FAIL fwd_invisible got %h exp 11223344", ld_data);
        end
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        checks++;
        if (ld_data !== 32'h112233EE) begin
            errors++; $display("FAIL fwd_merge got %h exp 112233ee", ld_data);
        end
        // Oldest entry is draining this cycle but still forwards.
        drive(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
        tick();
        tick();
        drive(1'b1, 32'h30, 32'h0000FF00, 4'h2, 32'h3008, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
        ld_addr = 32'h30; dm_rd = 32'h12345678; #1;
        checks++;
        if (ld_data !== 32'h1234FF78) begin
            errors++; $display("FAIL fwd_lane1 got %h exp 1234ff78", ld_data);
        end
        ld_addr = 32'h34; #1;
        checks++;
        if (ld_data !== 32'h12345678) begin
            errors++; $display("FAIL fwd_miss got %h exp 12345678", ld_data);
        end
        tick();
    endtask

    task automatic test_full_push_pop_wrap();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h200 + 32'(4*i), 32'h100 + 32'(i), 4'hF, 32'h4000 + 32'(i), 1'b0);
            tick();
        end
        drive(1'b1, 32'h2F0, 32'h0000DEAD, 4'hF, 32'h4FFF, 1'b1);
        checks++;
        if (dm_we !== 1'b1 || dm_wd !== 32'h100) begin
            errors++; $display("FAIL fullpp_drain got we=%b wd=%h exp we=1 wd=00000100", dm_we, dm_wd);
        end
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        checks++;
        if (count !== 3'd3) begin
            errors++; $display("FAIL fullpp_count got %0d exp 3", count);
        end
        for (int j = 0; j < 16; j++) begin
            if (j % 2 == 0 && j < 8) drive(1'b1, 32'h300 + 32'(4*j), 32'h200 + 32'(j), 4'hF, 32'h5000 + 32'(j), 1'b0);
            else drive(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
            if (dm_we) begin
                checks++;
                if (q.size() == 0 || dm_wd !== q[0].wd || dm_addr !== {q[0].a, 2'b00} || dm_wd === 32'h0000DEAD) begin
                    errors++; $display("FAIL wrap_order%0d got wd=%h a=%h", j, dm_wd, dm_addr);
                end
            end
            tick();
        end
        checks++;
        if (count !== 3'd0 || q.size() != 0) begin
            errors++; $display("FAIL wrap_final got cnt=%0d exp 0", count);
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h400 + 32'(4*i), 32'hF00D0000 | 32'(i), 4'hF, 32'h6000 + 32'(i), 1'b0);
            tick();
        end
        reset = 1'b1;
        drive(1'b1, 32'h400, 32'h99999999, 4'hF, 32'h6010, 1'b1);
        tick();
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
        ld_addr = 32'h404; dm_rd = 32'h13572468; #1;
        checks++;
        if (count !== 3'd0 || dm_we !== 1'b0 || ld_data !== 32'h13572468) begin
            errors++;
            $display("FAIL reset_mid got cnt=%0d we=%b ld=%h exp cnt=0 we=0 ld=13572468", count, dm_we, ld_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_ld;
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 2) != 0, 32'h800 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)),
                  $urandom, 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 2) == 0);
            ld_addr = 32'h800 + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
            dm_rd = $urandom;
            #1;
            exp_ld = model_ld(ld_addr, dm_rd);
            checks++;
            if (count !== 3'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == 4) ||
                st_ready !== (q.size() != 4) || dm_we !== ((q.size() != 0) && drain_en)) begin
                errors++;
                $display("FAIL rnd_flags%0d got cnt=%0d e=%b f=%b rdy=%b we=%b exp cnt=%0d", n, count, empty, full,
                         st_ready, dm_we, q.size());
            end
            checks++;
            if (ld_data !== exp_ld) begin
                errors++; $display("FAIL rnd_ld%0d got %h exp %h", n, ld_data, exp_ld);
            end
            if (q.size() != 0) begin
                checks++;
                if (dm_addr !== {q[0].a, 2'b00} || dm_wd !== q[0].wd || dm_be !== q[0].be || dm_pc !== q[0].pc) begin
                    errors++;
                    $display("FAIL rnd_head%0d got a=%h wd=%h be=%h pc=%h exp a=%h wd=%h be=%h pc=%h", n, dm_addr,
                             dm_wd, dm_be, dm_pc, {q[0].a, 2'b00}, q[0].wd, q[0].be, q[0].pc);
                end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_wd = '0; st_be = '0; st_pc = '0;
        drain_en = 1'b0; ld_addr = '0; dm_rd = '0;
        #1;
        test_reset();
        test_basic_drain();
        test_full_drop();
        test_forward();
        test_full_push_pop_wrap();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
